state_receiver: RTL and testbench

Receiving end of the inter-board game-state link. Deserializes the SPI-style frame (data line, data clock, active-low select) driven by the opponent board's transmitter into a data_t player record plus a scored flag. Detects the opponent "started" condition (clock held high while idle) and flags framing errors. Sits between the board-to-board input pins and the game FSM, in the pixel-clock domain.

---
 rtl/state_receiver_pkg.sv | 27 ++
 rtl/state_receiver_sync_edge.sv | 32 +++
 rtl/state_receiver.sv | 126 ++++++++++++
 tb/tb_state_receiver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/state_receiver_pkg.sv
// Shared game-state link types: player record layout and frame width
// used by both the transmitter and the receiver.
package state_receiver_pkg;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
  } location_t;

  typedef struct packed {
    logic [2:0]  lives;
    location_t   head;
    location_t   tail;
    logic [31:0] score;
    logic [9:0]  flags;
  } data_t;

  // record bits plus the trailing scored flag
  localparam int STATE_FRAME_BITS = $bits(data_t) + 1;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    IDLE       = 2'd1,
    RX         = 2'd2
  } rx_state_t;

endpackage

// File: rtl/state_receiver_sync_edge.sv
// N-stage synchronizer for one asynchronous pin, with single-cycle
// rising/falling strobes on the synchronized level.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/state_receiver.sv
// Receiving end of the board-to-board game-state link: deserializes the
// select-framed serial stream into a player record plus scored flag.
module state_receiver
  import state_receiver_pkg::*;
#(
  parameter int DATA_WIDTH        = STATE_FRAME_BITS,
  parameter int START_HOLD_CYCLES = 1024,
  parameter int SYNC_STAGES       = 2
) (
  input  logic  clk_pixel_in,
  input  logic  rst_n_in,
  input  logic  data_in,
  input  logic  data_clk_in,
  input  logic  sel_in,
  output logic  opponent_started_out,
  output data_t player_data_out,
  output logic  player_scored_out,
  output logic  data_valid_out,
  output logic  frame_error_out
);

  localparam int HOLD_W = $clog2(START_HOLD_CYCLES + 1);
  localparam int CNT_W  = $clog2(DATA_WIDTH + 2);

  logic data_q, data_rise, data_fall;
  logic dclk_q, dclk_rise, dclk_fall;
  logic sel_q, sel_rise, sel_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_data (
    .clk(clk_pixel_in), .rst_n(rst_n_in), .din(data_in),
    .q(data_q), .rise(data_rise), .fall(data_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dclk (
    .clk(clk_pixel_in), .rst_n(rst_n_in), .din(data_clk_in),
    .q(dclk_q), .rise(dclk_rise), .fall(dclk_fall)
  );
  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sel (
    .clk(clk_pixel_in), .rst_n(rst_n_in), .din(sel_in),
    .q(sel_q), .rise(sel_rise), .fall(sel_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{data_rise, data_fall, dclk_fall};

  rx_state_t             state, state_nxt;
  logic [HOLD_W-1:0]     hold_cnt, hold_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic                  started_nxt;
  logic                  frame_ok, frame_bad;
  logic                  pend_ok, pend_bad;

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state                <= WAIT_START;
      hold_cnt             <= '0;
      bit_cnt              <= '0;
      shift                <= '0;
      opponent_started_out <= 1'b0;
      pend_ok              <= 1'b0;
      pend_bad             <= 1'b0;
      data_valid_out       <= 1'b0;
      frame_error_out      <= 1'b0;
      player_data_out      <= '0;
      player_scored_out    <= 1'b0;
    end else begin
      state                <= state_nxt;
      hold_cnt             <= hold_nxt;
      bit_cnt              <= bit_nxt;
      shift                <= shift_nxt;
      opponent_started_out <= started_nxt;
      pend_ok              <= frame_ok;
      pend_bad             <= frame_bad;
      data_valid_out       <= pend_ok;
      frame_error_out      <= pend_bad;
      // shift is frozen in IDLE, so it still holds the frame one cycle on
      if (pend_ok) begin
        player_data_out   <= data_t'(shift[DATA_WIDTH-1:1]);
        player_scored_out <= shift[0];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold_cnt;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift;
    started_nxt = opponent_started_out;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      WAIT_START: begin
        if (sel_q && dclk_q) begin
          if (hold_cnt == HOLD_W'(START_HOLD_CYCLES - 1)) begin
            started_nxt = 1'b1;
            state_nxt   = IDLE;
          end else begin
            hold_nxt = hold_cnt + 1'b1;
          end
        end else begin
          hold_nxt = '0;
        end
      end
      IDLE: begin
        if (sel_fall) begin
          bit_nxt   = '0;
          state_nxt = RX;
        end
      end
      RX: begin
        // end of frame takes priority over a coincident clock edge
        if (sel_rise) begin
          if (bit_cnt == CNT_W'(DATA_WIDTH)) frame_ok = 1'b1;
          else                               frame_bad = 1'b1;
          state_nxt = IDLE;
        end else if (dclk_rise && !sel_q) begin
          shift_nxt = {shift[DATA_WIDTH-2:0], data_q};
          if (bit_cnt != CNT_W'(DATA_WIDTH + 1)) bit_nxt = bit_cnt + 1'b1;
        end
      end
      default: state_nxt = WAIT_START;
    endcase
  end

endmodule

// File: tb/tb_state_receiver.sv
// Directed bench for state_receiver: start detection, frame table, and
// reset/framing corner cases against hand-computed expectations.
module tb_state_receiver;
  import state_receiver_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n, din, dclk, sel;
  logic  started, scored, valid, ferr;
  data_t pdata;

  state_receiver dut (
    .clk_pixel_in(clk), .rst_n_in(rst_n), .data_in(din), .data_clk_in(dclk),
    .sel_in(sel), .opponent_started_out(started), .player_data_out(pdata),
    .player_scored_out(scored), .data_valid_out(valid), .frame_error_out(ferr)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  int cyc = 0, v_cnt = 0, e_cnt = 0, both_cnt = 0, last_valid_cyc = 0, rise_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin v_cnt++; last_valid_cyc = cyc; end
      if (ferr) e_cnt++;
      if (valid && ferr) both_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // clock idles high; data set on the falling half, sampled on the rise
  task automatic send_frame(input logic [95:0] bits, input int n);
    sel = 1'b0;
    tick(100);
    for (int i = n - 1; i >= 0; i--) begin
      dclk = 1'b0;
      din  = bits[i];
      tick(50);
      dclk = 1'b1;
      tick(50);
    end
    sel = 1'b1;
    rise_cyc = cyc;
    tick(200);
  endtask

  typedef struct {
    string       name;
    logic [95:0] bits;
    int          nbits;
    int          exp_valid;
    int          exp_err;
    logic [88:0] exp_data;
    logic        exp_scored;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [88:0] pa, pb;
    int base_v, base_e, rise_at;
    pa = {3'b101, 76'b0, 10'b0101010101};
    pb = 89'h1_23_4567_89AB_CDEF_0123_4567;
    vecs[0] = '{"good_a",  {7'b0, pa, 1'b1},           90, 1, 0, pa,  1'b1};
    vecs[1] = '{"good_b",  {7'b0, pb, 1'b0},           90, 1, 0, pb,  1'b0};
    vecs[2] = '{"short45", 96'h0000_0000_1555_5555_5555, 45, 0, 1, pb,  1'b0};
    vecs[3] = '{"long91",  {4'b0, 2'b11, pa, 1'b1},    91, 0, 1, pb,  1'b0};
    vecs[4] = '{"good_c",  {7'b0, ~pa, 1'b1},          90, 1, 0, ~pa, 1'b1};

    // reset state
    rst_n = 1'b0; sel = 1'b1; dclk = 1'b1; din = 1'b0;
    tick(5);
    chk("rst_started", started, 0);
    chk("rst_data", pdata, 0);
    chk("rst_scored", scored, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", ferr, 0);
    rst_n = 1'b1;
    tick(10);

    // a frame during WAIT_START is ignored
    base_v = v_cnt; base_e = e_cnt;
    send_frame(vecs[0].bits, 90);
    chk("prestart_valid", v_cnt - base_v, 0);
    chk("prestart_err", e_cnt - base_e, 0);
    chk("prestart_data", pdata, 0);

    // interrupted hold, then exactly START_HOLD_CYCLES clean cycles
    tick(300);
    chk("hold_interrupted", started, 0);
    dclk = 1'b0;
    tick(3);
    dclk = 1'b1;
    rise_at = 0;
    for (int n = 1; n <= 1100; n++) begin
      tick(1);
      if (started && rise_at == 0) rise_at = n;
      if (n == 1023) chk("hold_1023", started, 0);
    end
    // sync delay (2) puts the 1024th counted cycle at edge 1026
    chk("hold_start_cycle", rise_at, 1026);
    chk("started_sticky", started, 1);

    // frame table
    for (int k = 0; k < 5; k++) begin
      base_v = v_cnt; base_e = e_cnt;
      send_frame(vecs[k].bits, vecs[k].nbits);
      chk({vecs[k].name, "_valid"}, v_cnt - base_v, vecs[k].exp_valid);
      chk({vecs[k].name, "_err"}, e_cnt - base_e, vecs[k].exp_err);
      chk({vecs[k].name, "_data"}, pdata, vecs[k].exp_data);
      chk({vecs[k].name, "_scored"}, scored, vecs[k].exp_scored);
      if (k == 0) chk("valid_latency", last_valid_cyc - rise_cyc, 4);
    end
    chk("valid_err_overlap", both_cnt, 0);

    // reset mid-frame discards the partial frame
    base_v = v_cnt; base_e = e_cnt;
    sel = 1'b0;
    tick(100);
    for (int i = 0; i < 10; i++) begin
      dclk = 1'b0; din = i[0]; tick(50);
      dclk = 1'b1; tick(50);
    end
    rst_n = 1'b0;
    tick(3);
    chk("midrst_started", started, 0);
    chk("midrst_data", pdata, 0);
    chk("midrst_scored", scored, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_err", ferr, 0);
    sel = 1'b1;
    rst_n = 1'b1;
    tick(50);
    chk("midrst_no_valid", v_cnt - base_v, 0);
    chk("midrst_no_err", e_cnt - base_e, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
